// File: rtl/mux_arb_nto1.sv
// N-to-1 valid/ready channel selector with ctrl-directed or round-robin grant,
// feeding a registered single-entry output stage and a saturating transfer counter.
module mux_arb_nto1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 16,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        ctrl,
  input  logic [NUM_IN-1:0]       in_valid,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]       in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        xfer_cnt
);

  logic                 vld_p1;
  logic [WIDTH-1:0]     data_p1;
  logic [SEL_W-1:0]     src_p1;
  logic [CNT_W-1:0]     cnt_p1;
  logic [SEL_W-1:0]     ptr;
  logic                 load;
  logic                 gnt_vld;
  logic [SEL_W-1:0]     gnt_idx;
  logic                 xfer;
  logic [WIDTH-1:0]     sel_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] g);
    return (g == SEL_W'(NUM_IN - 1)) ? '0 : g + 1'b1;
  endfunction

  // Grant: direct index in mode 0, first valid channel scanning up from ptr in mode 1
  always_comb begin
    int idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    if (!mode) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (ctrl == SEL_W'(i) && in_valid[i]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        idx = int'(ptr) + k;
        if (idx >= NUM_IN) idx = idx - NUM_IN;
        if (!gnt_vld && in_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = SEL_W'(idx);
        end
      end
    end
  end

  assign load     = !vld_p1 || out_ready;
  assign xfer     = load && gnt_vld && !rst;
  assign in_ready = xfer ? (NUM_IN'(1) << gnt_idx) : '0;
  assign sel_data = in_data[int'(gnt_idx)*WIDTH +: WIDTH];

  // Stage p1: output register, counter and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      src_p1  <= '0;
      cnt_p1  <= '0;
      ptr     <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      src_p1  <= gnt_idx;
      cnt_p1  <= sat_inc(cnt_p1);
      if (mode) ptr <= wrap_inc(gnt_idx);
    end else if (out_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_src   = src_p1;
  assign xfer_cnt  = cnt_p1;

endmodule

// File: tb/tb_mux_arb_nto1.sv
// Bench for mux_arb_nto1: a 4-channel and a 3-channel instance driven side by side
// and compared every cycle against a queue-free arithmetic model of the selector.
module tb_mux_arb_nto1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mode, out_ready;
  logic [1:0]   ctrl4, os4, ctrl3, os3;
  logic [3:0]   iv4, ir4;
  logic [127:0] id4;
  logic         ov4, ov3;
  logic [31:0]  od4;
  logic [15:0]  cnt4, od3;
  logic [2:0]   iv3, ir3;
  logic [47:0]  id3;
  logic [3:0]   cnt3;

  mux_arb_nto1 #(.WIDTH(32), .NUM_IN(4), .CNT_W(16)) u4 (
    .clk(clk), .rst(rst), .mode(mode), .ctrl(ctrl4), .in_valid(iv4), .in_data(id4),
    .in_ready(ir4), .out_valid(ov4), .out_data(od4), .out_src(os4),
    .out_ready(out_ready), .xfer_cnt(cnt4));

  mux_arb_nto1 #(.WIDTH(16), .NUM_IN(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst), .mode(mode), .ctrl(ctrl3), .in_valid(iv3), .in_data(id3),
    .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_src(os3),
    .out_ready(out_ready), .xfer_cnt(cnt3));

  // Per-instance stimulus (index 0 = 4-channel, 1 = 3-channel)
  int          ctrlv[2];
  logic [15:0] iv[2];
  logic [31:0] dv[2][16];

  always_comb begin
    ctrl4 = ctrlv[0][1:0];
    ctrl3 = ctrlv[1][1:0];
    iv4   = iv[0][3:0];
    iv3   = iv[1][2:0];
    id4   = '0;
    id3   = '0;
    for (int c = 0; c < 4; c++) id4[c*32 +: 32] = dv[0][c];
    for (int c = 0; c < 3; c++) id3[c*16 +: 16] = dv[1][c][15:0];
  end

  // Reference model state
  int          m_vld[2], m_src[2], m_cnt[2], m_ptr[2];
  logic [31:0] m_data[2];
  int          NCH[2]  = '{4, 3};
  int          CMAX[2] = '{65535, 15};
  logic [31:0] MASK[2] = '{32'hFFFF_FFFF, 32'h0000_FFFF};

  int n_chk, n_pass;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int grant(int n, int md, int c, logic [15:0] v, int p);
    if (md == 0) begin
      if (c < n && v[c]) return c;
      return -1;
    end
    for (int k = 0; k < n; k++)
      if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  function automatic logic [31:0] obs_rdy(int i);
    return (i == 0) ? 32'(ir4) : 32'(ir3);
  endfunction
  function automatic logic [31:0] obs_vld(int i);
    return (i == 0) ? 32'(ov4) : 32'(ov3);
  endfunction
  function automatic logic [31:0] obs_data(int i);
    return (i == 0) ? od4 : 32'(od3);
  endfunction
  function automatic logic [31:0] obs_src(int i);
    return (i == 0) ? 32'(os4) : 32'(os3);
  endfunction
  function automatic logic [31:0] obs_cnt(int i);
    return (i == 0) ? 32'(cnt4) : 32'(cnt3);
  endfunction

  task automatic reset_model(int i);
    m_vld[i]  = 0;
    m_src[i]  = 0;
    m_cnt[i]  = 0;
    m_ptr[i]  = 0;
    m_data[i] = '0;
  endtask

  // One clock: check ready before the edge, advance the model, check the register after it
  task automatic step();
    int g[2];
    bit xf[2];
    #1;
    for (int i = 0; i < 2; i++) begin
      g[i]  = rst ? -1 : grant(NCH[i], int'(mode), ctrlv[i], iv[i] & 16'((1 << NCH[i]) - 1), m_ptr[i]);
      xf[i] = (g[i] >= 0) && (m_vld[i] == 0 || out_ready);
      chk($sformatf("in_ready[%0d]", i), obs_rdy(i), xf[i] ? (32'd1 << g[i]) : 32'd0);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rst) reset_model(i);
      else if (xf[i]) begin
        m_vld[i]  = 1;
        m_data[i] = dv[i][g[i]] & MASK[i];
        m_src[i]  = g[i];
        if (m_cnt[i] < CMAX[i]) m_cnt[i]++;
        if (mode) m_ptr[i] = (g[i] + 1) % NCH[i];
      end else if (m_vld[i] != 0 && out_ready) m_vld[i] = 0;
      chk($sformatf("out_valid[%0d]", i), obs_vld(i), 32'(m_vld[i]));
      chk($sformatf("out_data[%0d]", i), obs_data(i), m_data[i]);
      chk($sformatf("out_src[%0d]", i), obs_src(i), 32'(m_src[i]));
      chk($sformatf("xfer_cnt[%0d]", i), obs_cnt(i), 32'(m_cnt[i]));
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 16; c++) dv[i][c] = $urandom;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    mode = 1'b0;
    out_ready = 1'b1;
    ctrlv[0] = 0;
    ctrlv[1] = 0;
    iv[0] = 16'hF;
    iv[1] = 16'h7;
    for (int i = 0; i < 2; i++) begin
      reset_model(i);
      for (int c = 0; c < 16; c++) dv[i][c] = 32'hA5A5_0000 + 32'(c);
    end

    // Reset with every channel valid
    @(posedge clk);
    #1;
    chk("rst_rdy4", 32'(ir4), 32'd0);
    chk("rst_rdy3", 32'(ir3), 32'd0);
    chk("rst_vld4", 32'(ov4), 32'd0);
    chk("rst_data4", od4, 32'd0);
    chk("rst_cnt4", 32'(cnt4), 32'd0);
    step();
    iv[0] = '0;
    iv[1] = '0;
    rst = 1'b0;
    step();
    step();

    // ctrl-directed select
    dv[0][0] = 32'h1111_1111;
    dv[0][1] = 32'h2222_2222;
    dv[0][2] = 32'h3333_3333;
    dv[0][3] = 32'h4444_4444;
    ctrlv[0] = 2;
    ctrlv[1] = 2;
    iv[0] = 16'hF;
    iv[1] = 16'h7;
    repeat (3) begin
      step();
      chk("ctrl_src", 32'(os4), 32'd2);
      chk("ctrl_data", od4, 32'h3333_3333);
    end
    ctrlv[0] = 1;
    iv[0] = 16'b1101;
    ctrlv[1] = 3;
    step();
    chk("ctrl_drop", 32'(ov4), 32'd0);
    chk("ctrl_oob", 32'(ov3), 32'd0);
    step();

    // Round-robin fairness from ptr=0
    apply_reset();
    mode = 1'b1;
    iv[0] = 16'hF;
    iv[1] = 16'h7;
    for (int k = 0; k < 8; k++) begin
      rand_data();
      step();
      chk("rr4_seq", 32'(os4), 32'(k % 4));
      chk("rr3_seq", 32'(os3), 32'(k % 3));
    end
    chk("rr4_cnt", 32'(cnt4), 32'd8);

    // Backpressure then same-cycle refill
    out_ready = 1'b0;
    repeat (3) begin
      rand_data();
      iv[0] = 16'($urandom);
      iv[1] = 16'($urandom);
      step();
      chk("bp_hold", 32'(ov4), 32'd1);
    end
    out_ready = 1'b1;
    iv[0] = 16'hF;
    iv[1] = 16'h7;
    step();

    // Skip and wrap: land ptr on 3, then skip to ch1 and wrap to ch0
    iv[0] = 16'b0100;
    step();
    chk("wrap_pre", 32'(os4), 32'd2);
    iv[0] = 16'b0010;
    step();
    chk("skip_src", 32'(os4), 32'd1);
    iv[0] = 16'b0001;
    step();
    chk("wrap_src", 32'(os4), 32'd0);

    // Counter saturation on the 4-bit instance
    apply_reset();
    iv[1] = 16'h7;
    repeat (20) begin
      rand_data();
      step();
    end
    chk("sat_cnt3", 32'(cnt3), 32'd15);

    // Asynchronous reset between edges
    #3;
    rst = 1'b1;
    #1;
    chk("arst_vld4", 32'(ov4), 32'd0);
    chk("arst_vld3", 32'(ov3), 32'd0);
    chk("arst_cnt4", 32'(cnt4), 32'd0);
    chk("arst_cnt3", 32'(cnt3), 32'd0);
    chk("arst_rdy4", 32'(ir4), 32'd0);
    reset_model(0);
    reset_model(1);
    step();
    rst = 1'b0;

    // Randomised traffic
    repeat (400) begin
      mode = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      ctrlv[0] = $urandom_range(0, 3);
      ctrlv[1] = $urandom_range(0, 3);
      iv[0] = 16'($urandom);
      iv[1] = 16'($urandom);
      rand_data();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
